// File: rtl/ff_pkg.sv
// Shared types and the per-bit next-state rule for the multimode flip-flop bank.
package ff_pkg;

    typedef enum logic [1:0] {
        FF_D  = 2'd0,
        FF_T  = 2'd1,
        FF_SR = 2'd2,
        FF_JK = 2'd3
    } ff_mode_t;

    // SR with both inputs high holds; the bank reports it separately as invalid.
    function automatic logic ff_next(input ff_mode_t mode, input logic a,
                                     input logic b, input logic q);
        logic nxt;
        nxt = q;
        case (mode)
            FF_D:  nxt = a;
            FF_T:  nxt = q ^ a;
            FF_SR: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    default: nxt = q;
                endcase
            end
            FF_JK: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    2'b11:   nxt = ~q;
                    default: nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ff_err_logger.sv
// Sticky error flag and saturating per-edge error counter.
module ff_err_logger #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_event,
    input  logic             clr,
    output logic             sticky,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A clear on the same edge as an event restarts the log with that event.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= 1'b0;
            cnt    <= '0;
        end else if (clr) begin
            sticky <= err_event;
            cnt    <= err_event ? CNT_W'(1) : '0;
        end else if (err_event) begin
            sticky <= 1'b1;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH flip-flops with a shared run-time mode (D/T/SR/JK) and invalid-SR logging.
module multimode_ff_bank
    import ff_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter int                CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] inv_mask,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    ff_mode_t         mode_e;
    logic [WIDTH-1:0] q_next;
    logic             sr_active;
    logic             err_event;

    assign mode_e    = ff_mode_t'(mode);
    assign sr_active = en && (mode_e == FF_SR);
    assign err_event = sr_active && (|(a & b));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign q_next[i] = ff_next(mode_e, a[i], b[i], q[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= RESET_VAL;
            inv_mask <= '0;
        end else begin
            if (en) begin
                q <= q_next;
            end
            inv_mask <= sr_active ? (a & b) : '0;
        end
    end

    assign qb = ~q;

    ff_err_logger #(
        .CNT_W(CNT_W)
    ) u_err_logger (
        .clk      (clk),
        .rst      (rst),
        .err_event(err_event),
        .clr      (err_clr),
        .sticky   (err_sticky),
        .cnt      (err_cnt)
    );

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed plan plus randomized stimulus against a bitwise-equation reference model.
module tb_multimode_ff_bank;

    localparam int         WIDTH = 4;
    localparam logic [3:0] RV    = 4'b0101;
    localparam int         CNT_W = 2;
    localparam int         EW    = 3 * WIDTH + 1 + CNT_W;

    localparam logic [1:0] M_D  = 2'd0;
    localparam logic [1:0] M_T  = 2'd1;
    localparam logic [1:0] M_SR = 2'd2;
    localparam logic [1:0] M_JK = 2'd3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] inv_mask;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;

    multimode_ff_bank #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .err_clr   (err_clr),
        .q         (q),
        .qb        (qb),
        .inv_mask  (inv_mask),
        .err_sticky(err_sticky),
        .err_cnt   (err_cnt)
    );

    // clock
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    // reference model state
    logic [WIDTH-1:0] m_q = '0;
    logic [WIDTH-1:0] m_inv = '0;
    logic             m_st = 1'b0;
    int               m_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Each mode written as its characteristic equation.
    function automatic logic [WIDTH-1:0] model_next(input logic [1:0] m, input logic [WIDTH-1:0] qv,
                                                    input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        case (m)
            M_D:     return av;
            M_T:     return qv ^ av;
            M_SR:    return (av & ~bv) | (qv & ~(av ^ bv));
            default: return (av & ~qv) | (~bv & qv);
        endcase
    endfunction

    task automatic model_update(input logic r, input logic e, input logic [1:0] m,
                                input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic c);
        logic ev;
        ev = e && (m == M_SR) && ((av & bv) != 0);
        if (r) begin
            m_q = RV; m_inv = '0; m_st = 1'b0; m_cnt = 0;
        end else begin
            if (c) begin
                m_st = 1'b0; m_cnt = 0;
            end
            if (e) m_q = model_next(m, m_q, av, bv);
            m_inv = (e && m == M_SR) ? (av & bv) : '0;
            if (ev) begin
                m_st = 1'b1;
                m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check_val("q",          32'(q),          32'(e[EW-1 -: WIDTH]));
        check_val("qb",         32'(qb),         32'(e[EW-1-WIDTH -: WIDTH]));
        check_val("inv_mask",   32'(inv_mask),   32'(e[EW-1-2*WIDTH -: WIDTH]));
        check_val("err_sticky", 32'(err_sticky), 32'(e[CNT_W]));
        check_val("err_cnt",    32'(err_cnt),    32'(e[CNT_W-1:0]));
    endtask

    // driver: apply inputs for one edge, predict, then check just after the edge
    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic c);
        @(negedge clk);
        rst = r; en = e; mode = m; a = av; b = bv; err_clr = c;
        model_update(r, e, m, av, bv, c);
        exp_q.push_back({m_q, ~m_q, m_inv, m_st, CNT_W'(m_cnt)});
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    initial begin : main
        logic [CNT_W-1:0] sat_seq [5];
        sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3;
        sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;

        // 1. reset
        drive(1, 1, M_D, 4'hF, 4'h0, 0);
        check_val("rst_q", 32'(q), 32'h5);
        check_val("rst_qb", 32'(qb), 32'hA);

        // 2. D then T
        drive(0, 1, M_D, 4'b1100, 4'h0, 0);
        check_val("d_q", 32'(q), 32'hC);
        drive(0, 1, M_T, 4'b0110, 4'h0, 0);
        check_val("t1_q", 32'(q), 32'hA);
        drive(0, 1, M_T, 4'b0110, 4'h0, 0);
        check_val("t2_q", 32'(q), 32'hC);

        // 3. SR with invalid bits
        drive(0, 1, M_D, 4'h0, 4'h0, 0);
        drive(0, 1, M_SR, 4'b1011, 4'b0011, 0);
        check_val("sr_q", 32'(q), 32'h8);
        check_val("sr_inv", 32'(inv_mask), 32'h3);
        check_val("sr_cnt", 32'(err_cnt), 32'h1);

        // 4. saturation then clear with en=0
        drive(0, 0, M_D, 4'h0, 4'h0, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, M_SR, 4'b0001, 4'b0001, 0);
            check_val("sat_cnt", 32'(err_cnt), 32'(sat_seq[i]));
        end
        drive(0, 0, M_SR, 4'hF, 4'hF, 1);
        check_val("clr_cnt", 32'(err_cnt), 32'h0);
        check_val("clr_inv", 32'(inv_mask), 32'h0);

        // 5. JK toggle, then enable low
        drive(0, 1, M_D, 4'b0101, 4'h0, 0);
        drive(0, 1, M_JK, 4'hF, 4'hF, 0);
        check_val("jk_q", 32'(q), 32'hA);
        check_val("jk_sticky", 32'(err_sticky), 32'h0);
        for (int i = 0; i < 3; i++) drive(0, 0, M_JK, 4'hF, 4'hF, 0);
        check_val("hold_q", 32'(q), 32'hA);

        // 6. clear/event collision, then reset mid-sequence
        drive(0, 1, M_SR, 4'b0010, 4'b0010, 0);
        drive(0, 1, M_SR, 4'b0100, 4'b0100, 0);
        check_val("pre_cnt", 32'(err_cnt), 32'h2);
        drive(0, 1, M_SR, 4'b1000, 4'b1000, 1);
        check_val("coll_cnt", 32'(err_cnt), 32'h1);
        check_val("coll_sticky", 32'(err_sticky), 32'h1);
        drive(1, 1, M_SR, 4'hF, 4'hF, 1);
        check_val("rst2_q", 32'(q), 32'h5);
        check_val("rst2_cnt", 32'(err_cnt), 32'h0);

        // random phase
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 11) == 0));
        end

        check_val("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multimode_ff_bank.md
Name: multimode_ff_bank

Overview:
- Parametrised bank of WIDTH flip-flops sharing one clock and one run-time selectable mode: D, T, SR or JK.
- Successor to the single-bit SR flip-flop. The SR both-asserted case is defined (hold plus error report) instead of producing X.
- Adds a per-bit invalid-event mask, a sticky error flag and a saturating error counter.
- Used as a generic control/status register primitive in datapath and FSM blocks.

Parameters:
- WIDTH, 8: number of flip-flops in the bank (≥1).
- RESET_VAL, 0: q value loaded on reset. WIDTH bits, zero-extended or truncated.
- CNT_W, 8: width of the invalid-event counter (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  clock enable. When 0, q holds and no error is logged.
- mode  input  2  function select: 0 = D, 1 = T, 2 = SR, 3 = JK. Shared by all bits.
- a  input  WIDTH  per-bit primary control: D / T / S / J.
- b  input  WIDTH  per-bit secondary control: ignored / ignored / R / K.
- err_clr  input  1  clears err_sticky and err_cnt.
- q  output  WIDTH  flip-flop state.
- qb  output  WIDTH  always ~q, including during and after reset. Never X.
- inv_mask  output  WIDTH  registered: bits that saw S=R=1 on the previous enabled SR-mode edge.
- err_sticky  output  1  set by any invalid event, held until err_clr or rst.
- err_cnt  output  CNT_W  number of edges with ≥1 invalid bit, saturating at all-ones.

Behaviour:
- All state updates on posedge clk only. No combinational path from inputs to q, qb or inv_mask. qb is derived combinationally from q.
- Reset (rst=1), with priority over everything:
  - q = RESET_VAL, qb = ~RESET_VAL.
  - inv_mask = 0, err_sticky = 0, err_cnt = 0.
  - Reset asserted mid-operation takes effect at the next edge, regardless of en, mode or err_clr.
- When en=0 (rst=0):
  - q holds.
  - inv_mask is cleared to 0.
  - err_clr is still honoured.
- Per-bit next state i when en=1, one-cycle latency (input sampled at edge N, q visible after edge N):
  - D: q[i] ← a[i].
  - T: a[i]=1 toggles, else hold.
  - SR: (a,b)=00 hold; 10 set; 01 clear; 11 hold q[i] and mark bit i invalid.
  - JK: 00 hold; 10 set; 01 clear; 11 toggle.
- Invalid logging, active only with en=1 and mode=SR:
  - inv_mask ← a & b.
  - In any other mode, or with en=0, inv_mask ← 0.
- Error logging (event = |(a & b) with en=1 and mode=SR):
  - err_sticky ← 1 on any event.
  - err_cnt increments by 1 per edge, not per bit, and saturates at 2^CNT_W−1 with no wrap.
- Simultaneous err_clr and event on the same edge:
  - err_sticky = 1 and err_cnt = 1. Clear is applied first, then the event is logged.
  - inv_mask is unaffected by err_clr.
- Mode changes take effect on the same edge they are sampled; there is no pipeline. q is never altered by a mode change alone.
- X-free: no output is ever assigned X. Unknown mode encodings cannot occur because all 4 encodings are defined.

Decomposition:
- Shared package ff_pkg:
  - typedef ff_mode_t, 2-bit enum: FF_D = 0, FF_T = 1, FF_SR = 2, FF_JK = 3.
  - A function ff_next(mode, a, b, q) returning the next-state bit.
- One natural sub-module: ff_err_logger, holding err_sticky and the saturating err_cnt.
  - Inputs: clk, rst, event, clr.
  - Parameter: CNT_W.
- Bit cells are a generate loop calling ff_next, not a separate module.

Test Plan (WIDTH=4, RESET_VAL=4'b0101, CNT_W=2 unless noted):
1. Reset: rst=1 for 1 edge with en=1, mode=D, a=4'hF → q=4'b0101, qb=4'b1010, inv_mask=0, err_sticky=0, err_cnt=0.
2. D then T: mode=D, a=4'b1100 → q=4'b1100. Then mode=T, a=4'b0110 for 2 edges → q=4'b1010, then q=4'b1100.
3. SR with invalid bits: q=4'b0000, mode=SR, a=4'b1011, b=4'b0011 → q=4'b1000, inv_mask=4'b0011, err_sticky=1, err_cnt=1.
4. Counter saturation: 5 consecutive SR edges each with one invalid bit → err_cnt sequence 1, 2, 3, 3, 3. Then err_clr=1 with en=0 → err_sticky=0, err_cnt=0, q unchanged.
5. JK toggle and enable: q=4'b0101, mode=JK, a=b=4'b1111 → q=4'b1010, inv_mask=0, no error logged. Then en=0 with a=b=4'b1111 for 3 edges → q stays 4'b1010.
6. Clear/event collision: err_cnt=2, err_clr=1 on the same edge as an SR 11 event → err_cnt=1, err_sticky=1. Then rst=1 mid-sequence with en=1 → all outputs return to reset values on that edge.
